cdc_pulse_scheduler: RTL and testbench

Shares one closed-loop CDC pulse channel (pulse out, synchronized acknowledge back) among N_REQ requesters in the CLK domain. Latches single-cycle requests as sticky pending bits and grants them round-robin. Runs the full four-phase handshake on the channel per grant, so no pulse is lost or merged at the far domain. Sits between control/config logic (soft resets, triggers, counter clears) and the pulse synchronizer feeding a foreign clock domain.

---
 rtl/cdc_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/cdc_pulse_scheduler.sv | 143 ++++++++++++++
 tb/tb_cdc_pulse_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_sched_pkg.sv
// Shared types for the CDC pulse scheduler: FSM state encoding and a
// constant-width helper used to size index and counter fields.
package cdc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    // Bits needed to index n items; never less than 1 so 2-entry users get a real port.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending strictly after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter
    import cdc_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] pending,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         valid
);

    logic [W-1:0] idx;

    // NOTE: every output gets a default before the search loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/cdc_pulse_scheduler.sv
// Round-robin scheduler sharing one four-phase CDC pulse channel among N_REQ requesters.
// Optional per-phase handshake abort is enabled by defining CDC_PULSE_SCHED_TIMEOUT_EN.
module cdc_pulse_scheduler
    import cdc_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MIN_GAP = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          REQ,
    output logic [N_REQ-1:0]          PENDING,
    output logic [N_REQ-1:0]          DONE,
    output logic                      BUSY,
    output logic [clog2(N_REQ)-1:0]   GRANT_ID,
    output logic                      CH_PULSE,
    input  logic                      CH_ACK,
    output logic                      TIMEOUT_ERR,
    input  logic                      ERR_CLR
);

    localparam int             GW       = clog2(N_REQ);
    localparam logic [GW-1:0]  PTR_INIT = GW'(N_REQ - 1);
    localparam logic [7:0]     GAP_LAST = 8'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam state_t         POST_HS  = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;

    state_t            state;
    logic [GW-1:0]     rr_ptr;
    logic [7:0]        gap_cnt;
    logic              repend;
    logic [GW-1:0]     arb_grant;
    logic              arb_valid;
    logic              in_hs;
    logic              finish;
    logic              timeout_hit;
    logic [N_REQ-1:0]  grant_onehot;
    logic [N_REQ-1:0]  clr_vec;

    rr_arbiter #(.N(N_REQ), .W(GW)) u_arb (
        .pending (PENDING),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    assign in_hs        = (state == ST_ASSERT) || (state == ST_RELEASE);
    assign finish       = ((state == ST_RELEASE) && !CH_ACK) || timeout_hit;
    assign grant_onehot = N_REQ'(1) << GRANT_ID;
    // A request from the served requester during its own handshake keeps its bit alive past DONE.
    assign clr_vec      = (finish && !repend) ? grant_onehot : '0;

`ifdef CDC_PULSE_SCHED_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          phase_wait;

    assign phase_wait  = ((state == ST_ASSERT) && !CH_ACK) || ((state == ST_RELEASE) && CH_ACK);
    assign timeout_hit = phase_wait && (to_cnt == TW'(TIMEOUT));

    // Counter restarts on every phase change because phase_wait drops for the transition cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_cnt      <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            to_cnt <= (phase_wait && !timeout_hit) ? to_cnt + 1'b1 : '0;
            if (timeout_hit)  TIMEOUT_ERR <= 1'b1;
            else if (ERR_CLR) TIMEOUT_ERR <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign timeout_hit    = 1'b0;
    assign TIMEOUT_ERR    = 1'b0;
    assign unused_err_clr = ERR_CLR;
`endif

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            PENDING  <= '0;
            DONE     <= '0;
            BUSY     <= 1'b0;
            GRANT_ID <= '0;
            CH_PULSE <= 1'b0;
            rr_ptr   <= PTR_INIT;
            gap_cnt  <= '0;
            repend   <= 1'b0;
        end else begin
            DONE    <= '0;
            PENDING <= (PENDING & ~clr_vec) | REQ;

            if (finish)                     repend <= 1'b0;
            else if (in_hs && REQ[GRANT_ID]) repend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    // A stale high acknowledge means the far side has not drained yet.
                    if (arb_valid && !CH_ACK) begin
                        GRANT_ID <= arb_grant;
                        rr_ptr   <= arb_grant;
                        CH_PULSE <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (CH_ACK) begin
                        CH_PULSE <= 1'b0;
                        state    <= ST_RELEASE;
                    end else if (timeout_hit) begin
                        CH_PULSE <= 1'b0;
                        BUSY     <= (MIN_GAP != 0);
                        gap_cnt  <= '0;
                        state    <= POST_HS;
                    end
                end
                ST_RELEASE: begin
                    if (!CH_ACK || timeout_hit) begin
                        if (!CH_ACK) DONE <= grant_onehot;
                        BUSY    <= (MIN_GAP != 0);
                        gap_cnt <= '0;
                        state   <= POST_HS;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Directed bench for cdc_pulse_scheduler: cycle table with hand-driven acknowledge,
// then far-end-model sequences for ordering, coalescing, reset and stall corners.
module tb_cdc_pulse_scheduler;

    localparam int N  = 4;
    localparam int MG = 2;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] pending;
    logic [N-1:0] done;
    logic         busy;
    logic [1:0]   grant_id;
    logic         ch_pulse;
    logic         ch_ack;
    logic         timeout_err;
    logic         err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cdc_pulse_scheduler #(.N_REQ(N), .MIN_GAP(MG), .TIMEOUT(TO)) dut (
        .CLK         (clk),
        .RST         (rst),
        .REQ         (req),
        .PENDING     (pending),
        .DONE        (done),
        .BUSY        (busy),
        .GRANT_ID    (grant_id),
        .CH_PULSE    (ch_pulse),
        .CH_ACK      (ch_ack),
        .TIMEOUT_ERR (timeout_err),
        .ERR_CLR     (err_clr)
    );

    // Far-end model: ack 4 cycles after the pulse rises, release 4 cycles after it drops.
    logic far_auto = 1'b0;
    int   hi_cnt   = 0;
    int   lo_cnt   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (far_auto) begin
                if (ch_pulse && !ch_ack) begin
                    hi_cnt++;
                    if (hi_cnt >= 4) begin ch_ack = 1'b1; hi_cnt = 0; end
                end else hi_cnt = 0;
                if (!ch_pulse && ch_ack) begin
                    lo_cnt++;
                    if (lo_cnt >= 4) begin ch_ack = 1'b0; lo_cnt = 0; end
                end else lo_cnt = 0;
            end else begin
                hi_cnt = 0;
                lo_cnt = 0;
            end
        end
    end

    // Monitor: grant order per pulse rise, shortest low run between pulses, DONE counts.
    int   gq[$];
    int   done_cnt[N];
    int   min_low;
    int   low_run;
    logic prev_pulse;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (ch_pulse && !prev_pulse) begin
                    if (gq.size() > 0 && low_run < min_low) min_low = low_run;
                    gq.push_back(int'(grant_id));
                end
                low_run = ch_pulse ? 0 : low_run + 1;
                for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
            end
            prev_pulse = ch_pulse;
        end
    end

    task automatic clear_mon();
        gq.delete();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        min_low    = 1000;
        low_run    = 0;
        prev_pulse = ch_pulse;
    endtask

    function automatic logic [63:0] order_code();
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < gq.size(); i++) c = (c << 4) | 64'(gq[i]);
        return c;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_min(input string name, input int act, input int lo);
        total++;
        if (act < lo) begin
            bad++;
            $display("FAIL %s: got %0d expected at least %0d", name, act, lo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        req     = '0;
        err_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fire(input logic [N-1:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_level(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (ch_pulse !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: CH_PULSE stayed %0b for %0d cycles, required %0b", name, ch_pulse, n, lvl);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((pending != '0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s: not idle after %0d cycles (pending=%b busy=%b), required idle", name, n, pending, busy);
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] pend;
        logic [N-1:0] done;
        logic         busy;
        logic         pulse;
        logic [1:0]   gid;
    } vec_t;

    vec_t vecs[32];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int any_pulse;
        int hi;

        // Per-cycle table: inputs applied before an edge, outputs expected after it (MIN_GAP=2).
        vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0};
        vecs[3]  = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0};
        vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd0};
        vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0};
        vecs[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{4'b0110, 1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0, 2'd0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[10] = '{4'b0010, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[11] = '{4'b0000, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[12] = '{4'b0000, 1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[13] = '{4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[14] = '{4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0, 2'd1};
        vecs[15] = '{4'b0000, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b1, 2'd2};
        vecs[16] = '{4'b0000, 1'b1, 4'b0110, 4'b0000, 1'b1, 1'b0, 2'd2};
        vecs[17] = '{4'b0000, 1'b0, 4'b0010, 4'b0100, 1'b1, 1'b0, 2'd2};
        vecs[18] = '{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd2};
        vecs[19] = '{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd2};
        vecs[20] = '{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1};
        vecs[21] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[22] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd1};
        vecs[23] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1};
        vecs[24] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1};
        vecs[25] = '{4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd1};
        vecs[26] = '{4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd1};
        vecs[27] = '{4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1, 2'd3};
        vecs[28] = '{4'b0000, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd3};
        vecs[29] = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'd3};
        vecs[30] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3};
        vecs[31] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3};

        rst     = 1'b1;
        req     = '0;
        ch_ack  = 1'b0;
        err_clr = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        check("reset_outputs", {pending, done, busy, grant_id, ch_pulse, timeout_err}, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {pending, done, busy, grant_id, ch_pulse, timeout_err}, '0);

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            req    = vecs[i].req;
            ch_ack = vecs[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {pending, done, busy, ch_pulse, grant_id, timeout_err},
                  {vecs[i].pend, vecs[i].done, vecs[i].busy, vecs[i].pulse, vecs[i].gid, 1'b0});
        end
        @(negedge clk);
        req = '0;

        // All four at once: served 0,1,2,3 with gaps between channel pulses.
        do_reset();
        far_auto = 1'b1;
        clear_mon();
        fire(4'b1111);
        wait_idle(400, "all4_idle");
        check("all4_count", 64'(gq.size()), 64'd4);
        check("all4_order", order_code(), 64'h0123);
        check_min("all4_min_gap", min_low, MG);
        check("all4_done", {32'(done_cnt[3]), 8'(done_cnt[2]), 8'(done_cnt[1]), 8'(done_cnt[0])}, {32'd1, 8'd1, 8'd1, 8'd1});

        // Coalescing: three REQ[1] pulses while 0 is in service give one service of 1.
        do_reset();
        clear_mon();
        fire(4'b0001);
        wait_level(1'b1, 10, "coal_rise");
        repeat (3) fire(4'b0010);
        wait_idle(400, "coal_idle");
        check("coal_order", {32'(gq.size()), order_code()[31:0]}, {32'd2, 32'h01});
        check("coal_done1", 64'(done_cnt[1]), 64'd1);

        // Fairness: 0 and 2 re-fired during the first two handshakes -> 0,2,0,2.
        do_reset();
        clear_mon();
        fire(4'b0101);
        for (int h = 0; h < 2; h++) begin
            wait_level(1'b1, 40, "fair_rise");
            fire(4'b0101);
            wait_level(1'b0, 40, "fair_fall");
        end
        wait_idle(400, "fair_idle");
        check("fair_order", {32'(gq.size()), order_code()[31:0]}, {32'd4, 32'h0202});
        check("fair_done", {32'(done_cnt[0]), 32'(done_cnt[2])}, {32'd2, 32'd2});

        // Reset mid-ASSERT with the channel ack stuck high afterwards.
        do_reset();
        far_auto = 1'b0;
        ch_ack   = 1'b0;
        fire(4'b0001);
        wait_level(1'b1, 10, "rst_rise");
        @(negedge clk);
        ch_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {ch_pulse, busy, pending}, '0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        fire(4'b1000);
        any_pulse = 0;
        repeat (10) begin
            @(negedge clk);
            if (ch_pulse) any_pulse = 1;
        end
        check("stale_ack_block", 64'(any_pulse), 64'd0);
        check("stale_pending", 64'(pending), 64'b1000);
        ch_ack   = 1'b0;
        far_auto = 1'b1;
        wait_level(1'b1, 5, "drain_rise");
        check("drain_grant", 64'(grant_id), 64'd3);
        wait_idle(400, "drain_idle");
        check("drain_done3", 64'(done_cnt[3]), 64'd1);

`ifdef CDC_PULSE_SCHED_TIMEOUT_EN
        // Ack never returns: pulse held for TIMEOUT+1 cycles, then abort without DONE.
        do_reset();
        far_auto = 1'b0;
        ch_ack   = 1'b0;
        clear_mon();
        fire(4'b0001);
        wait_level(1'b1, 10, "to_rise");
        hi = 1;
        while (hi < 100) begin
            @(negedge clk);
            if (!ch_pulse) break;
            hi++;
        end
        check("to_high_cycles", 64'(hi), 64'd16);
        check("to_err_set", {timeout_err, pending}, {1'b1, 4'b0000});
        wait_idle(20, "to_idle");
        check("to_no_done", 64'(done_cnt[0]), 64'd0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_clr", 64'(timeout_err), 64'd0);
        far_auto = 1'b1;
        fire(4'b0010);
        wait_idle(400, "to_next_idle");
        check("to_next_done", {32'(done_cnt[1]), 32'(timeout_err)}, {32'd1, 32'd0});
`else
        // Without the abort feature a stalled handshake simply waits.
        do_reset();
        far_auto = 1'b0;
        ch_ack   = 1'b0;
        clear_mon();
        err_clr = 1'b1;
        fire(4'b0001);
        wait_level(1'b1, 10, "stall_rise");
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (ch_pulse) hi++;
        end
        check("stall_held", {32'(hi), 16'(busy), 16'(timeout_err)}, {32'd40, 16'd1, 16'd0});
        err_clr  = 1'b0;
        far_auto = 1'b1;
        wait_idle(400, "stall_idle");
        check("stall_done", 64'(done_cnt[0]), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
